// File: rtl/config_bus_arbiter_if.sv
// Config bus bundle between the requesters, the arbiter and one core's
// config port. The arbiter uses the slave view, the requesters/core the master.
interface config_bus_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            resp_valid;
   logic [DATA_WIDTH-1:0]         resp_data;
   logic                          busy;
   logic [ADDR_WIDTH-1:0]         config_config_addr;
   logic [DATA_WIDTH-1:0]         config_config_data;
   logic                          config_read;
   logic                          config_write;
   logic [DATA_WIDTH-1:0]         read_config_data;

   modport master (
      output req_valid, req_write, req_addr, req_data,
      output read_config_data,
      input  req_ready, resp_valid, resp_data, busy,
      input  config_config_addr, config_config_data,
      input  config_read, config_write
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      input  read_config_data,
      output req_ready, resp_valid, resp_data, busy,
      output config_config_addr, config_config_data,
      output config_read, config_write
   );
endinterface

// File: rtl/config_bus_arbiter.sv
// Round-robin arbiter sharing one core config bus between NUM_REQ requesters,
// sequencing each accepted request into config_write / config_read strobes.
module config_bus_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   config_bus_arbiter_if.slave bus
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(READ_LATENCY + 2);

   typedef enum logic [2:0] {
      IDLE, WRITE, READ, WAIT, RESP
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]         gnt_q, gnt_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [2*NUM_REQ-1:0]  dbl;
   logic [NUM_REQ-1:0]    rot;
   logic [PW:0]           sum;
   logic [PW-1:0]         sel;
   logic                  found;
   logic [NUM_REQ-1:0]    ready;
   logic [PW-1:0]         rr_nxt;

   // Rotate so bit 0 is the current priority holder; first set bit wins.
   assign dbl = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
   assign rot = dbl[NUM_REQ-1:0];

   always_comb begin
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr_q} + (PW+1)'(k);
         end
      end
      if (sum >= (PW+1)'(NUM_REQ)) begin
         sum = sum - (PW+1)'(NUM_REQ);
      end
      sel = sum[PW-1:0];
   end

   assign ready = (state_q == IDLE && found && !reset)
                ? (NUM_REQ'(1) << sel) : '0;

   assign rr_nxt = (gnt_q == PW'(NUM_REQ - 1))
                 ? '0 : gnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d   = sel;
               state_d = READ;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (sel == PW'(i)) begin
                     addr_d  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                     wdata_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                     if (bus.req_write[i]) begin
                        state_d = WRITE;
                        rdata_d = '0;
                     end
                  end
               end
            end
         end
         WRITE: begin
            rr_ptr_d = rr_nxt;
            state_d  = IDLE;
         end
         READ: begin
            if (READ_LATENCY == 0) begin
               rdata_d = bus.read_config_data;
               state_d = RESP;
            end else begin
               cnt_d   = CW'(READ_LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               rdata_d = bus.read_config_data;
               state_d = RESP;
            end
         end
         RESP: begin
            rr_ptr_d = rr_nxt;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.req_ready          = ready;
   assign bus.busy               = (state_q != IDLE);
   assign bus.config_write       = (state_q == WRITE);
   assign bus.config_read        = (state_q == READ);
   assign bus.config_config_addr = addr_q;
   assign bus.config_config_data = wdata_q;
   assign bus.resp_data          = rdata_q;
   assign bus.resp_valid         = (state_q == WRITE || state_q == RESP)
                                 ? (NUM_REQ'(1) << gnt_q) : '0;

endmodule

// File: tb/tb_config_bus_arbiter.sv
// Bench for config_bus_arbiter: vector table plus response scoreboard,
// with READ_LATENCY 0 and 3 instances for the latency corner cases.
module tb_config_bus_arbiter;

   localparam int RL = 1;

   typedef struct {
      int          r;
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   typedef struct {
      int          r;
      bit          wr;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] exp_data;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        lat_en;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [15:0] req_addr;
   logic [63:0] req_data;

   int   cyc;
   int   n_vec;
   int   n_bad;
   exp_t sbq[$];
   exp_t mon_e;

   logic [31:0] core_mem [256];
   bit          core_init;

   config_bus_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) m_if ();
   config_bus_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) l0_if ();
   config_bus_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) l3_if ();

   config_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32),
                        .READ_LATENCY(RL)) dut (
      .clk(clk), .reset(reset), .bus(m_if.slave));

   config_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32),
                        .READ_LATENCY(0)) dut_l0 (
      .clk(clk), .reset(reset), .bus(l0_if.slave));

   config_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32),
                        .READ_LATENCY(3)) dut_l3 (
      .clk(clk), .reset(reset), .bus(l3_if.slave));

   assign m_if.req_valid  = req_valid;
   assign m_if.req_write  = req_write;
   assign m_if.req_addr   = req_addr;
   assign m_if.req_data   = req_data;
   assign l0_if.req_valid = lat_en ? req_valid : 2'b00;
   assign l0_if.req_write = req_write;
   assign l0_if.req_addr  = req_addr;
   assign l0_if.req_data  = req_data;
   assign l3_if.req_valid = lat_en ? req_valid : 2'b00;
   assign l3_if.req_write = req_write;
   assign l3_if.req_addr  = req_addr;
   assign l3_if.req_data  = req_data;

   // Latency builds see data that changes every cycle to pin the capture cycle.
   assign m_if.read_config_data  = core_mem[m_if.config_config_addr];
   assign l0_if.read_config_data = core_mem[l0_if.config_config_addr] ^ 32'(cyc);
   assign l3_if.read_config_data = core_mem[l3_if.config_config_addr] ^ 32'(cyc);

   function automatic logic [31:0] dflt(input logic [7:0] a);
      return (a == 8'h00) ? 32'h12345678 : {24'hC0FFEE, a};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!core_init) begin
         for (int i = 0; i < 256; i++) core_mem[i] <= dflt(8'(i));
         core_init <= 1'b1;
      end else if (m_if.config_write) begin
         core_mem[m_if.config_config_addr] <= m_if.config_config_data;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_vec++;
      n_bad++;
      $display("FAIL %s: timed out at cycle %0d", nm, cyc);
   endtask

   task automatic push_exp(input int r, input logic [7:0] a,
                           input logic [31:0] d, input int lat);
      exp_t e;
      e.r    = r;
      e.addr = a;
      e.data = d;
      e.cyc  = cyc + lat;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (m_if.config_read && m_if.config_write) begin
            chk("strobe_excl", 1, 0);
         end
         if (m_if.resp_valid != 2'b00) begin
            if (sbq.size() == 0) begin
               chk("unexpected_resp", 64'(m_if.resp_valid), 0);
            end else begin
               mon_e = sbq.pop_front();
               chk("resp_valid", 64'(m_if.resp_valid), 64'(2'b01 << mon_e.r));
               chk("resp_data", 64'(m_if.resp_data), 64'(mon_e.data));
               chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
               chk("resp_addr", 64'(m_if.config_config_addr), 64'(mon_e.addr));
            end
         end
      end
   end

   task automatic set_req(input int r, input bit wr,
                          input logic [7:0] a, input logic [31:0] d);
      req_valid[r]        = 1'b1;
      req_write[r]        = wr;
      req_addr[r*8 +: 8]  = a;
      req_data[r*32 +: 32] = d;
   endtask

   task automatic issue(input int r, input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] xd,
                        output int t_hs);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      set_req(r, wr, a, d);
      for (int i = 0; i < 32 && !got; i++) begin
         @(negedge clk);
         if (m_if.req_ready != 2'b00) got = 1'b1;
      end
      t_hs = cyc;
      if (!got) begin
         fail("handshake");
         req_valid = 2'b00;
         return;
      end
      chk("grant", 64'(m_if.req_ready), 64'(2'b01 << r));
      push_exp(r, a, wr ? 32'h0 : xd, wr ? 1 : 2 + RL);
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      @(negedge clk);
      chk("config_write", 64'(m_if.config_write), 64'(wr));
      chk("config_read", 64'(m_if.config_read), 64'(!wr));
      chk("config_addr", 64'(m_if.config_config_addr), 64'(a));
      if (wr) chk("config_data", 64'(m_if.config_config_data), 64'(d));
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         fail("drain");
         sbq.delete();
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 64'(m_if.req_ready), 0);
      chk({tag, "_resp_valid"}, 64'(m_if.resp_valid), 0);
      chk({tag, "_resp_data"}, 64'(m_if.resp_data), 0);
      chk({tag, "_busy"}, 64'(m_if.busy), 0);
      chk({tag, "_addr"}, 64'(m_if.config_config_addr), 0);
      chk({tag, "_data"}, 64'(m_if.config_config_data), 0);
      chk({tag, "_rd"}, 64'(m_if.config_read), 0);
      chk({tag, "_wr"}, 64'(m_if.config_write), 0);
   endtask

   vec_t vt[9];
   logic [1:0] rr_pat[8];

   initial begin
      int t;
      int c0, c3;
      logic [31:0] d0, d3;
      logic [1:0]  v0, v3;
      bit got;

      vt[0] = '{1, 1'b0, 8'h00, 32'h0,        32'h12345678};
      vt[1] = '{1, 1'b0, 8'h01, 32'h0,        32'hDEADBEEF};
      vt[2] = '{0, 1'b0, 8'h7F, 32'h0,        32'hC0FFEE7F};
      vt[3] = '{1, 1'b1, 8'hFF, 32'hCAFEF00D, 32'h0};
      vt[4] = '{0, 1'b0, 8'hFF, 32'h0,        32'hCAFEF00D};
      vt[5] = '{0, 1'b1, 8'h80, 32'h00000001, 32'h0};
      vt[6] = '{1, 1'b0, 8'h80, 32'h0,        32'h00000001};
      vt[7] = '{1, 1'b1, 8'h40, 32'hA5A5A5A5, 32'h0};
      vt[8] = '{1, 1'b0, 8'h40, 32'h0,        32'hA5A5A5A5};
      rr_pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

      n_vec = 0;
      n_bad = 0;
      lat_en = 1'b0;
      reset = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr = '0;
      req_data = '0;

      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      req_valid = 2'b00;

      issue(0, 1'b1, 8'h01, 32'hDEADBEEF, 32'h0, t);
      @(negedge clk);
      chk("busy_after_write", 64'(m_if.busy), 0);

      for (int i = 0; i < 9; i++) begin
         issue(vt[i].r, vt[i].wr, vt[i].a, vt[i].d, vt[i].exp_data, t);
      end
      drain();

      pulse_reset();
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr  = {8'h31, 8'h30};
      req_data  = {32'h11110001, 32'h00000000};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rr_grant", 64'(m_if.req_ready), 64'(rr_pat[k]));
         if (rr_pat[k] == 2'b01) push_exp(0, 8'h30, 32'h0, 1);
         if (rr_pat[k] == 2'b10) push_exp(1, 8'h31, 32'h0, 1);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();

      pulse_reset();
      lat_en = 1'b1;
      c0 = -1;
      c3 = -1;
      d0 = '0;
      d3 = '0;
      v0 = '0;
      v3 = '0;
      issue(0, 1'b0, 8'h01, 32'h0, 32'hDEADBEEF, t);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (l0_if.resp_valid != 2'b00 && c0 < 0) begin
            c0 = cyc;
            d0 = l0_if.resp_data;
            v0 = l0_if.resp_valid;
         end
         if (l3_if.resp_valid != 2'b00 && c3 < 0) begin
            c3 = cyc;
            d3 = l3_if.resp_data;
            v3 = l3_if.resp_valid;
         end
      end
      chk("lat0_cycle", 64'(c0), 64'(t + 2));
      chk("lat0_valid", 64'(v0), 64'(2'b01));
      chk("lat0_data", 64'(d0), 64'(32'hDEADBEEF ^ 32'(t + 1)));
      chk("lat3_cycle", 64'(c3), 64'(t + 5));
      chk("lat3_valid", 64'(v3), 64'(2'b01));
      chk("lat3_data", 64'(d3), 64'(32'hDEADBEEF ^ 32'(t + 4)));
      lat_en = 1'b0;
      drain();

      issue(1, 1'b0, 8'h00, 32'h0, 32'h12345678, t);
      @(posedge clk); #1;
      set_req(0, 1'b1, 8'h55, 32'h55555555);
      @(negedge clk);
      chk("wait_ready", 64'(m_if.req_ready), 0);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("resp_ready", 64'(m_if.req_ready), 0);
      @(negedge clk);
      chk("idle_ready", 64'(m_if.req_ready), 0);
      chk("idle_busy", 64'(m_if.busy), 0);
      drain();

      got = 1'b0;
      @(posedge clk); #1;
      set_req(1, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 16 && !got; i++) begin
         @(negedge clk);
         if (m_if.req_ready != 2'b00) got = 1'b1;
      end
      if (!got) fail("abort_handshake");
      chk("abort_grant", 64'(m_if.req_ready), 64'(2'b10));
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #2;
      chk("abort_busy", 64'(m_if.busy), 1);
      reset = 1'b1;
      #1;
      chk_all_zero("abort");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort_no_resp", 64'(m_if.resp_valid), 0);
         chk("abort_no_rd", 64'(m_if.config_read), 0);
      end
      @(posedge clk); #1;
      set_req(0, 1'b1, 8'h20, 32'h20202020);
      set_req(1, 1'b1, 8'h21, 32'h21212121);
      @(negedge clk);
      chk("post_reset_grant", 64'(m_if.req_ready), 64'(2'b01));
      push_exp(0, 8'h20, 32'h0, 1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/config_bus_arbiter.md
Name: config_bus_arbiter

Overview:
- Shares one core's configuration bus between NUM_REQ requesters, e.g. global controller and JTAG, using round-robin arbitration.
- Sequences each accepted transaction into core-side strobes: config_write for writes; config_read plus a fixed read-latency wait and data capture for reads.
- Sits between the tile-level config network and a core's config_config_* / read_config_data ports.
- Only one transaction is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (≥1)
ADDR_WIDTH, 8, config address width
DATA_WIDTH, 32, config data width
READ_LATENCY, 1, cycles from the config_read strobe to valid read_config_data (≥0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_write  input  NUM_REQ  per-requester: 1=write, 0=read
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
req_ready  output  NUM_REQ  one-hot grant/accept
resp_valid  output  NUM_REQ  one-cycle completion pulse to the owning requester
resp_data  output  DATA_WIDTH  read data; 0 for write completions
busy  output  1  high whenever state≠IDLE
config_config_addr  output  ADDR_WIDTH  core config address (registered)
config_config_data  output  DATA_WIDTH  core config write data (registered)
config_read  output  1  core read strobe
config_write  output  1  core write strobe
read_config_data  input  DATA_WIDTH  core read data

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready, resp_valid, resp_data, busy, config_config_addr, config_config_data, config_read, config_write.
  - Reset mid-transaction aborts it: no strobe and no resp_valid is issued afterwards.
- State machine: IDLE, WRITE, READ, WAIT, RESP.
- IDLE:
  - Grant index g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready is combinational: one-hot at g, or 0 if no valid. req_ready is 0 in every other state.
  - A handshake (req_valid[g]&req_ready[g]) at edge T latches g, req_addr[g] into config_config_addr, req_data[g] into config_config_data, and req_write[g].
  - Next state is WRITE if req_write[g], else READ.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- WRITE (cycle T+1):
  - config_write=1 for exactly one cycle.
  - resp_valid[g]=1 with resp_data=0.
  - rr_ptr←(g+1) mod NUM_REQ, then → IDLE.
- READ (cycle T+1):
  - config_read=1 for exactly one cycle.
  - READ_LATENCY=0: capture read_config_data into resp_data this cycle, → RESP.
  - READ_LATENCY>0: load wait counter with READ_LATENCY, → WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter reads 1, capture read_config_data, → RESP. The capture therefore occurs READ_LATENCY cycles after the READ cycle.
- RESP:
  - resp_valid[g]=1 for one cycle; resp_data holds the captured value.
  - rr_ptr←(g+1) mod NUM_REQ, → IDLE.
- Read round trip: accept at T, strobe at T+1, resp at T+2+READ_LATENCY.
- Write round trip: accept at T, strobe and resp at T+1.
- config_config_addr and config_config_data are registered and hold their last value until the next handshake. The address stays stable through READ/WAIT/RESP because the core's read mux decodes it.
- resp_data holds its last value when resp_valid=0.
- Responses have no backpressure; a requester must accept resp_valid when it arrives.
- Dropping req_valid without a handshake is legal and has no effect.
- req_* inputs are ignored outside the handshake cycle.
- config_read and config_write are never high together; each is high at most one cycle per transaction.
- rr_ptr wraps NUM_REQ-1 → 0.
- NUM_REQ=1 degenerates to pass-through sequencing.

Test Plan:
- Reset released; req0 writes addr 0x01, data 0xDEADBEEF → req_ready=01 at T; at T+1 config_write=1, addr=0x01, data=0xDEADBEEF, resp_valid=01, resp_data=0; at T+2 busy=0.
- READ_LATENCY=1; core returns 0x12345678 for addr 0x00; req1 reads 0x00 → config_read=1 at T+1, resp_valid=10 and resp_data=0x12345678 at T+3; config_config_addr=0x00 throughout T+1..T+3.
- Both requesters valid continuously with writes from reset → grants alternate 0,1,0,1; each req_ready pulse is 2 cycles apart; no requester is granted twice in a row.
- READ_LATENCY=0 build; read addr 0x01 → resp at T+2 carrying the data present during the config_read cycle. READ_LATENCY=3 build → resp at T+5.
- Assert reset during WAIT of a read → all outputs 0 immediately; no resp_valid after release; the next request is granted from rr_ptr=0.
- req0 raises valid for one cycle while in WAIT, then drops it → no grant to req0; after the current resp, state returns to IDLE with req_ready=00.
